money_store: RTL and testbench

- Two-account balance register file for the vending machine: one customer wallet and one machine cash box.
- Merges the read path (getMoney) and write path (setMoney) into one block.
- The cash-handling controller reads a balance, computes the new value itself, then writes it back.
- No arithmetic or validation inside; the block only stores, returns and initialises values.

---
 rtl/money_store.sv | 78 +++++++
 tb/tb_money_store.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/money_store.sv
// Two-account balance store (customer wallet, machine cash box) with registered read port.
// Optional MONEY_STORE_BYPASS_EN: same-account read+write returns wr_value (write-first).
module money_store #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned CUST_INIT = 0,
    parameter int unsigned MACH_INIT = 0
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             rd_en,
    input  logic             rd_mode,
    output logic [WIDTH-1:0] rd_value,
    output logic             rd_valid,
    input  logic             wr_en,
    input  logic             wr_mode,
    input  logic [WIDTH-1:0] wr_value,
    output logic [WIDTH-1:0] cust_balance,
    output logic [WIDTH-1:0] mach_balance
);

    localparam logic [WIDTH-1:0] CustRst = WIDTH'(CUST_INIT);
    localparam logic [WIDTH-1:0] MachRst = WIDTH'(MACH_INIT);

    logic [WIDTH-1:0] cust_q, cust_d;
    logic [WIDTH-1:0] mach_q, mach_d;
    logic [WIDTH-1:0] rd_value_q, rd_value_d;
    logic             rd_valid_q, rd_valid_d;
    logic [WIDTH-1:0] rd_sel;

    always_comb begin
        cust_d     = cust_q;
        mach_d     = mach_q;
        rd_value_d = rd_value_q;
        rd_valid_d = 1'b0;
        rd_sel     = rd_mode ? cust_q : mach_q;

        if (wr_en) begin
            if (wr_mode) begin
                cust_d = wr_value;
            end else begin
                mach_d = wr_value;
            end
        end

`ifdef MONEY_STORE_BYPASS_EN
        // Forward the incoming write so the caller sees its update in one cycle.
        if (wr_en && (wr_mode == rd_mode)) begin
            rd_sel = wr_value;
        end
`endif

        // rd_sel is only consumed under rd_en, so an X rd_mode while idle is harmless.
        if (rd_en) begin
            rd_value_d = rd_sel;
            rd_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cust_q     <= CustRst;
            mach_q     <= MachRst;
            rd_value_q <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            cust_q     <= cust_d;
            mach_q     <= mach_d;
            rd_value_q <= rd_value_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd_value     = rd_value_q;
    assign rd_valid     = rd_valid_q;
    assign cust_balance = cust_q;
    assign mach_balance = mach_q;

endmodule

// File: tb/tb_money_store.sv
// Self-checking bench for money_store (CUST_INIT=5, MACH_INIT=9); reads are scored via a queue.
module tb_money_store;

    localparam int unsigned W = 4;

    logic         clock;
    logic         reset_n;
    logic         rd_en;
    logic         rd_mode;
    logic [W-1:0] rd_value;
    logic         rd_valid;
    logic         wr_en;
    logic         wr_mode;
    logic [W-1:0] wr_value;
    logic [W-1:0] cust_balance;
    logic [W-1:0] mach_balance;

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_v;
    logic [W-1:0] cust_m;
    logic [W-1:0] mach_m;

    money_store #(
        .WIDTH    (W),
        .CUST_INIT(5),
        .MACH_INIT(9)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .rd_en       (rd_en),
        .rd_mode     (rd_mode),
        .rd_value    (rd_value),
        .rd_valid    (rd_valid),
        .wr_en       (wr_en),
        .wr_mode     (wr_mode),
        .wr_value    (wr_value),
        .cust_balance(cust_balance),
        .mach_balance(mach_balance)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic re, input logic rm, input logic we, input logic wm,
                         input logic [W-1:0] wv);
        rd_en    = re;
        rd_mode  = rm;
        wr_en    = we;
        wr_mode  = wm;
        wr_value = wv;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
        step();
        step();
        n_tests++;
        if (cust_balance !== 4'd5 || mach_balance !== 4'd9) begin
            n_fail++;
            $display("FAIL reset_balances got cust=%0d mach=%0d exp cust=5 mach=9",
                     cust_balance, mach_balance);
        end
        n_tests++;
        if (rd_value !== 4'd0 || rd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_read got value=%0d valid=%b exp value=0 valid=0",
                     rd_value, rd_valid);
        end
        reset_n = 1'b1;
        cust_m  = 4'd5;
        mach_m  = 4'd9;
        step();
        n_tests++;
        if (rd_valid !== 1'b0 || cust_balance !== 4'd5 || mach_balance !== 4'd9) begin
            n_fail++;
            $display("FAIL after_release got valid=%b cust=%0d mach=%0d exp valid=0 cust=5 mach=9",
                     rd_valid, cust_balance, mach_balance);
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
        exp_q.push_back(4'd9);
        step();
        exp_v = exp_q.pop_front();
        n_tests++;
        if (rd_valid !== 1'b1 || rd_value !== exp_v) begin
            n_fail++;
            $display("FAIL first_read_mach got value=%0d valid=%b exp value=%0d valid=1",
                     rd_value, rd_valid, exp_v);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic test_write_read();
        drive(1'b0, 1'b0, 1'b1, 1'b1, 4'd12);
        cust_m = 4'd12;
        step();
        n_tests++;
        if (cust_balance !== cust_m || mach_balance !== mach_m) begin
            n_fail++;
            $display("FAIL write_cust got cust=%0d mach=%0d exp cust=%0d mach=%0d",
                     cust_balance, mach_balance, cust_m, mach_m);
        end
        drive(1'b1, 1'b1, 1'b0, 1'b0, '0);
        exp_q.push_back(cust_m);
        step();
        exp_v = exp_q.pop_front();
        n_tests++;
        if (rd_valid !== 1'b1 || rd_value !== exp_v) begin
            n_fail++;
            $display("FAIL read_cust got value=%0d valid=%b exp value=%0d valid=1",
                     rd_value, rd_valid, exp_v);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
        step();
        n_tests++;
        if (rd_valid !== 1'b0 || rd_value !== 4'd12) begin
            n_fail++;
            $display("FAIL read_idle_hold got value=%0d valid=%b exp value=12 valid=0",
                     rd_value, rd_valid);
        end
    endtask

    task automatic test_same_account();
        drive(1'b1, 1'b1, 1'b1, 1'b1, 4'd3);
`ifdef MONEY_STORE_BYPASS_EN
        exp_q.push_back(4'd3);
`else
        exp_q.push_back(4'd12);
`endif
        cust_m = 4'd3;
        step();
        exp_v = exp_q.pop_front();
        n_tests++;
        if (rd_valid !== 1'b1 || rd_value !== exp_v) begin
            n_fail++;
            $display("FAIL same_acct_read got value=%0d valid=%b exp value=%0d valid=1",
                     rd_value, rd_valid, exp_v);
        end
        n_tests++;
        if (cust_balance !== cust_m) begin
            n_fail++;
            $display("FAIL same_acct_commit got cust=%0d exp cust=%0d", cust_balance, cust_m);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic test_boundary();
        logic [W-1:0] vals[2];
        vals[0] = 4'd15;
        vals[1] = 4'd0;
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b0, vals[i]);
            mach_m = vals[i];
            step();
            drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
            exp_q.push_back(mach_m);
            step();
            exp_v = exp_q.pop_front();
            n_tests++;
            if (rd_valid !== 1'b1 || rd_value !== exp_v || mach_balance !== mach_m) begin
                n_fail++;
                $display("FAIL boundary_%0d got value=%0d mach=%0d exp %0d", i, rd_value,
                         mach_balance, exp_v);
            end
        end
        // Unknown controls with enables low must leave state alone.
        rd_en    = 1'b0;
        wr_en    = 1'b0;
        rd_mode  = 1'bx;
        wr_mode  = 1'bx;
        wr_value = 'x;
        step();
        n_tests++;
        if (cust_balance !== cust_m || mach_balance !== mach_m || rd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL x_idle got cust=%0d mach=%0d valid=%b exp cust=%0d mach=%0d valid=0",
                     cust_balance, mach_balance, rd_valid, cust_m, mach_m);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic test_diff_account();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 4'd7);
        exp_q.push_back(cust_m);
        mach_m = 4'd7;
        step();
        exp_v = exp_q.pop_front();
        n_tests++;
        if (rd_valid !== 1'b1 || rd_value !== exp_v || mach_balance !== mach_m) begin
            n_fail++;
            $display("FAIL diff_acct got value=%0d mach=%0d exp value=%0d mach=%0d",
                     rd_value, mach_balance, exp_v, mach_m);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic test_back_to_back();
        logic         re, rm, we, wm;
        logic [W-1:0] wv;
        for (int i = 0; i < 24; i++) begin
            re = 1'($urandom_range(1));
            rm = 1'($urandom_range(1));
            we = 1'($urandom_range(1));
            wm = 1'($urandom_range(1));
            wv = W'($urandom_range(15));
            drive(re, rm, we, wm, wv);
            if (re) begin
                exp_v = rm ? cust_m : mach_m;
`ifdef MONEY_STORE_BYPASS_EN
                if (we && wm == rm) exp_v = wv;
`endif
                exp_q.push_back(exp_v);
            end
            if (we && wm) cust_m = wv;
            if (we && !wm) mach_m = wv;
            step();
            n_tests++;
            if (re) begin
                exp_v = exp_q.pop_front();
                if (rd_valid !== 1'b1 || rd_value !== exp_v) begin
                    n_fail++;
                    $display("FAIL b2b_read_%0d got value=%0d valid=%b exp value=%0d valid=1",
                             i, rd_value, rd_valid, exp_v);
                end
            end else if (rd_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_idle_%0d got valid=%b exp valid=0", i, rd_valid);
            end
            n_tests++;
            if (cust_balance !== cust_m || mach_balance !== mach_m) begin
                n_fail++;
                $display("FAIL b2b_bal_%0d got cust=%0d mach=%0d exp cust=%0d mach=%0d",
                         i, cust_balance, mach_balance, cust_m, mach_m);
            end
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic test_async_reset();
        drive(1'b1, 1'b0, 1'b1, 1'b1, 4'd14);
        exp_q.push_back(mach_m);
        cust_m = 4'd14;
        step();
        exp_v = exp_q.pop_front();
        n_tests++;
        if (cust_balance !== 4'd14 || rd_valid !== 1'b1 || rd_value !== exp_v) begin
            n_fail++;
            $display("FAIL pre_reset got cust=%0d value=%0d valid=%b exp cust=14 value=%0d valid=1",
                     cust_balance, rd_value, rd_valid, exp_v);
        end
        // Pending operations that must be discarded by the reset.
        drive(1'b1, 1'b1, 1'b1, 1'b0, 4'd11);
        #2;
        reset_n = 1'b0;
        #1;
        n_tests++;
        if (cust_balance !== 4'd5 || mach_balance !== 4'd9 || rd_valid !== 1'b0 ||
            rd_value !== 4'd0) begin
            n_fail++;
            $display("FAIL async_reset got cust=%0d mach=%0d value=%0d valid=%b exp 5 9 0 0",
                     cust_balance, mach_balance, rd_value, rd_valid);
        end
        step();
        n_tests++;
        if (cust_balance !== 4'd5 || mach_balance !== 4'd9 || rd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_held got cust=%0d mach=%0d valid=%b exp 5 9 0",
                     cust_balance, mach_balance, rd_valid);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
        reset_n = 1'b1;
        cust_m  = 4'd5;
        mach_m  = 4'd9;
        step();
        n_tests++;
        if (cust_balance !== cust_m || mach_balance !== mach_m || rd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset got cust=%0d mach=%0d valid=%b exp 5 9 0",
                     cust_balance, mach_balance, rd_valid);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_same_account();
        test_boundary();
        test_diff_account();
        test_back_to_back();
        test_async_reset();
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain got %0d pending exp 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
